bounded_updown_counter: RTL and testbench
=========================================

// Module: bounded_updown_counter
//
// PURPOSE
//   Parametrised bounded up/down counter with synchronous load, count enable,
//   wrap or saturate mode at the bounds, and a registered terminal-count flag.
//   Generalises the fixed 8-bit 10..40 counter to any width, range and step.
//   Used as a sequencer/index generator in datapath control blocks.
//
// PARAMETERS
//   WIDTH     8   counter/data width in bits
//   MIN_VAL   10  lower bound (inclusive); also the reset value
//   MAX_VAL   40  upper bound (inclusive)
//   STEP      1   increment/decrement per counting cycle
//   WRAP      1   1 = wrap at bounds, 0 = saturate at bounds
//   PRESCALE  4   enabled cycles per step (used only with COUNTER_PRESCALE_EN)
//   Legal: MIN_VAL < MAX_VAL <= 2**WIDTH-1; 1 <= STEP <= MAX_VAL-MIN_VAL;
//   PRESCALE >= 1.
//
// PORTS
//   clk       in   1      clock, all state on rising edge
//   rst       in   1      asynchronous active-low reset
//   en        in   1      count enable
//   load      in   1      synchronous load request
//   data      in   WIDTH  load value
//   u_d       in   1      direction: 1 = up, 0 = down
//   count     out  WIDTH  current count, registered
//   tc        out  1      terminal count: high one cycle per boundary event
//   load_err  out  1      high one cycle after out-of-range load attempt
//
// BEHAVIOUR
//   - Reset (rst=0, async, no clock needed): count=MIN_VAL, tc=0,
//     load_err=0, prescale counter=0. All outputs registered, no comb paths.
//   - Priority per edge: load > en > hold. en=0 and load=0: count holds,
//     tc=0, load_err=0.
//   - load=1, MIN_VAL<=data<=MAX_VAL: count<=data, tc<=0, load_err<=0.
//   - load=1, data out of range: count holds, load_err<=1 for one cycle, tc<=0.
//   - en=1, up: arithmetic in WIDTH+1 bits (no overflow). If count+STEP<=MAX_VAL
//     then count+STEP; else WRAP=1 -> MIN_VAL, WRAP=0 -> MAX_VAL; tc<=1.
//   - en=1, down: if count-STEP>=MIN_VAL (signed WIDTH+1 compare) then
//     count-STEP; else WRAP=1 -> MAX_VAL, WRAP=0 -> MIN_VAL; tc<=1.
//   - tc asserts on the same edge that count takes the wrapped/saturated value;
//     in saturate mode tc repeats every blocked step.
//   - Wrap lands exactly on the opposite bound (no residual carry).
//   - Defensive: if count is ever outside [MIN_VAL,MAX_VAL] on a counting
//     edge, count<=MIN_VAL, tc<=1.
//   - Direction change takes effect on the next step; no latency penalty.
//
// CONFIGURATION
//   COUNTER_PRESCALE_EN defined: internal counter of clog2(PRESCALE) bits
//     advances on en=1; a step occurs only when it equals PRESCALE-1 (then
//     clears). load=1 clears it. en=0 holds it. tc/limits as above per step.
//   Not defined: every en=1 cycle is a step; PRESCALE ignored, no extra logic.
//
// TESTING (defaults unless stated)
//   1. rst=0 pulse mid-clock-period -> count=10, tc=0, load_err=0 before
//      next edge; hold after release with en=0 -> count stays 10.
//   2. load data=38, then en=1 u_d=1 x3 -> count 39,40,10; tc=1 only with 10.
//   3. load data=11, en=1 u_d=0 x3 -> count 10,40,39; tc=1 only with 40.
//   4. load data=50 -> count unchanged, load_err=1 one cycle; load=1 data=25
//      en=1 same cycle -> count=25 (load wins), tc=0.
//   5. WRAP=0, STEP=3: load 39, en up x2 -> 40,40, tc=1 both; down from 12
//      -> 10 (tc=1).
//   6. COUNTER_PRESCALE_EN, PRESCALE=4: count=10, en=1 for 8 cycles -> 11
//      after 4th edge, 12 after 8th; load mid-sequence restarts 4-cycle phase.

Source files
------------

// File: rtl/bounded_updown_counter_if.sv
// Control/status bundle for bounded_updown_counter.
// The master drives the load/count requests; the slave (the counter) returns
// the registered count, terminal-count and load-error flags.
interface bounded_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             u_d;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;

    modport master (
        output en, load, data, u_d,
        input  count, tc, load_err
    );

    modport slave (
        input  en, load, data, u_d,
        output count, tc, load_err
    );
endinterface

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with synchronous load, count enable, wrap or
// saturate at the bounds, and registered terminal-count / load-error flags.
// Optional feature macro: COUNTER_PRESCALE_EN -- when defined, a step happens
// only once every PRESCALE enabled cycles; when undefined every enabled cycle
// is a step and no prescale logic exists.
module bounded_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MIN_VAL  = 10,
    parameter int MAX_VAL  = 40,
    parameter int STEP     = 1,
    parameter bit WRAP     = 1'b1,
    parameter int PRESCALE = 4
) (
    input logic                     clk,
    input logic                     rst,
    bounded_updown_counter_if.slave bus
);
    // Arithmetic is done one bit wider than the counter so that count+STEP
    // never overflows and count-STEP can be compared as a signed value.
    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // Illegal parameter sets stop elaboration instead of building a broken counter.
    if ((MIN_VAL >= MAX_VAL) || ((MAX_VAL >> WIDTH) != 0) || (MIN_VAL < 0) ||
        (STEP < 1) || (STEP > MAX_VAL - MIN_VAL) || (PRESCALE < 1)) begin : g_bad_params
        $error("bounded_updown_counter: illegal parameter combination");
    end

    logic [WIDTH-1:0]        count_q;
    logic                    tc_q;
    logic                    err_q;
    logic [WIDTH-1:0]        count_d;
    logic                    tc_d;
    logic                    err_d;
    logic                    step;
    logic [WIDTH:0]          up_sum;
    logic signed [WIDTH:0]   dn_diff;
    logic                    cnt_ok;
    logic                    data_ok;

`ifdef COUNTER_PRESCALE_EN
    localparam int             PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q;

    // Prescale phase: a load restarts it, enabled cycles advance it, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            psc_q <= '0;
        else if (bus.load)
            psc_q <= '0;
        else if (bus.en)
            psc_q <= (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
    end

    assign step = bus.en && (psc_q == PSC_LAST);
`else
    assign step = bus.en;
`endif

    // Next-state for count and the two one-cycle flags; load beats counting.
    always_comb begin
        up_sum  = {1'b0, count_q} + STEP_X;
        dn_diff = $signed({1'b0, count_q}) - $signed(STEP_X);
        cnt_ok  = ({1'b0, count_q} >= MIN_X) && ({1'b0, count_q} <= MAX_X);
        data_ok = ({1'b0, bus.data} >= MIN_X) && ({1'b0, bus.data} <= MAX_X);
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            if (data_ok)
                count_d = bus.data;
            else
                err_d = 1'b1;
        end else if (step) begin
            if (!cnt_ok) begin
                // Corrupted state recovers to the reset value and flags it.
                count_d = MIN_W;
                tc_d    = 1'b1;
            end else if (bus.u_d) begin
                if (up_sum <= MAX_X) begin
                    count_d = up_sum[WIDTH-1:0];
                end else begin
                    count_d = WRAP ? MIN_W : MAX_W;
                    tc_d    = 1'b1;
                end
            end else begin
                if (dn_diff >= $signed(MIN_X)) begin
                    count_d = dn_diff[WIDTH-1:0];
                end else begin
                    count_d = WRAP ? MAX_W : MIN_W;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    // Output registers; reset is asynchronous so outputs clear without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= MIN_W;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_bounded_updown_counter.sv
// Bench for bounded_updown_counter: a default-parameter instance (wrap, step 1)
// and a saturating step-3 instance. Vectors carry hand-derived expectations
// that go through a scoreboard queue between drive and sample.
module tb_bounded_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bounded_updown_counter_if #(.WIDTH(8)) bus0 ();
    bounded_updown_counter_if #(.WIDTH(8)) bus1 ();

    bounded_updown_counter u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    bounded_updown_counter #(
        .WIDTH(8), .MIN_VAL(10), .MAX_VAL(40), .STEP(3), .WRAP(1'b0), .PRESCALE(4)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic       sel;     // 0 = default instance, 1 = saturating step-3
        logic       ld;
        logic       en;
        logic       ud;
        logic [7:0] data;
        logic [7:0] ecount;
        logic       etc;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic       sel;
        int         id;
        logic [7:0] c;
        logic       t;
        logic       e;
    } exp_t;

    exp_t sb[$];
    vec_t tab[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic sel, logic ld, logic en, logic ud, logic [7:0] data,
                                logic [7:0] ec, logic et, logic ee);
        vec_t v;
        v.sel = sel; v.ld = ld; v.en = en; v.ud = ud; v.data = data;
        v.ecount = ec; v.etc = et; v.eerr = ee;
        return v;
    endfunction

    task automatic check(input string nm, input int id, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, required %0d", nm, id, got, req);
        end
    endtask

    task automatic idle();
        bus0.en = 1'b0; bus0.load = 1'b0; bus0.u_d = 1'b1; bus0.data = 8'd0;
        bus1.en = 1'b0; bus1.load = 1'b0; bus1.u_d = 1'b1; bus1.data = 8'd0;
    endtask

    // Drive one vector for one cycle, then compare what the DUT registered.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        idle();
        if (v.sel == 1'b0) begin
            bus0.load = v.ld; bus0.en = v.en; bus0.u_d = v.ud; bus0.data = v.data;
        end else begin
            bus1.load = v.ld; bus1.en = v.en; bus1.u_d = v.ud; bus1.data = v.data;
        end
        e.sel = v.sel; e.id = id; e.c = v.ecount; e.t = v.etc; e.e = v.eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
            check("count0", e.id, bus0.count, e.c);
            check("tc0", e.id, 8'(bus0.tc), 8'(e.t));
            check("err0", e.id, 8'(bus0.load_err), 8'(e.e));
        end else begin
            check("count1", e.id, bus1.count, e.c);
            check("tc1", e.id, 8'(bus1.tc), 8'(e.t));
            check("err1", e.id, 8'(bus1.load_err), 8'(e.e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Reset state, checked while reset is still asserted.
        #12;
        check("rst_count0", 0, bus0.count, 8'd10);
        check("rst_count1", 0, bus1.count, 8'd10);
        check("rst_tc0", 0, 8'(bus0.tc), 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Move away from reset state and raise load_err, then reset mid-period.
        apply(mk(0, 1, 0, 1, 8'd30, 8'd30, 0, 0), 100);
        apply(mk(0, 1, 0, 1, 8'd50, 8'd30, 0, 1), 101);
        @(negedge clk);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 0, bus0.count, 8'd10);
        check("async_tc", 0, 8'(bus0.tc), 8'd0);
        check("async_err", 0, 8'(bus0.load_err), 8'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef COUNTER_PRESCALE_EN
        // Eight enabled cycles: step after the 4th and 8th edge.
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd11, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd11, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd11, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd11, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd12, 0, 0));
        // Two into a phase, then a load restarts the 4-cycle phase.
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd12, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd12, 0, 0));
        tab.push_back(mk(0, 1, 0, 1, 8'd20, 8'd20, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd20, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd20, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd20, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd21, 0, 0));
        // en=0 holds the phase.
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd21, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd21, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 8'd21, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd21, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd20, 0, 0));
        // Wrap on a prescaled step.
        tab.push_back(mk(0, 1, 0, 1, 8'd40, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 1, 0));
`else
        // Default instance: hold, up wrap, down wrap, bad loads, priority.
        tab.push_back(mk(0, 0, 0, 1, 0, 8'd10, 0, 0));
        tab.push_back(mk(0, 1, 0, 1, 8'd38, 8'd38, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd39, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 1, 0));
        tab.push_back(mk(0, 1, 0, 0, 8'd11, 8'd11, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd10, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd40, 1, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd39, 0, 0));
        tab.push_back(mk(0, 1, 0, 1, 8'd50, 8'd39, 0, 1));
        tab.push_back(mk(0, 0, 0, 1, 0, 8'd39, 0, 0));
        tab.push_back(mk(0, 1, 1, 1, 8'd25, 8'd25, 0, 0));
        tab.push_back(mk(0, 1, 0, 1, 8'd9, 8'd25, 0, 1));
        tab.push_back(mk(0, 1, 0, 1, 8'd10, 8'd10, 0, 0));
        tab.push_back(mk(0, 1, 0, 1, 8'd40, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 0, 0, 8'd39, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 0, 8'd10, 1, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 8'd10, 0, 0));
        // Saturating step-3 instance.
        tab.push_back(mk(1, 1, 0, 1, 8'd39, 8'd39, 0, 0));
        tab.push_back(mk(1, 0, 1, 1, 0, 8'd40, 1, 0));
        tab.push_back(mk(1, 0, 1, 1, 0, 8'd40, 1, 0));
        tab.push_back(mk(1, 1, 0, 0, 8'd12, 8'd12, 0, 0));
        tab.push_back(mk(1, 0, 1, 0, 0, 8'd10, 1, 0));
        tab.push_back(mk(1, 0, 1, 0, 0, 8'd10, 1, 0));
        tab.push_back(mk(1, 0, 1, 1, 0, 8'd13, 0, 0));
        tab.push_back(mk(1, 0, 1, 0, 0, 8'd10, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 8'd37, 8'd37, 0, 0));
        tab.push_back(mk(1, 0, 1, 1, 0, 8'd40, 0, 0));
        tab.push_back(mk(1, 0, 1, 1, 0, 8'd40, 1, 0));
        tab.push_back(mk(1, 0, 0, 1, 0, 8'd40, 0, 0));
`endif

        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], i);

        @(negedge clk);
        idle();
        if (sb.size() != 0)
            check("sb_left", 0, 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
